// File: rtl/mips_seq_if.sv
// Handshake bundle between the MIPS stage sequencer and the five datapath stages.
// The master modport is the sequencer's view; the slave modport is the stage/host side.
interface mips_seq_if #(
  parameter int unsigned PC_W  = 4,
  parameter int unsigned CNT_W = 16
);
  logic             start;
  logic [4:0]       stage_done;
  logic             branch_taken;
  logic [PC_W-1:0]  branch_target;
  logic             halt_req;
  logic [4:0]       stage_go;
  logic [PC_W-1:0]  pc_out;
  logic             busy;
  logic             halted;
  logic [CNT_W-1:0] instr_count;
  logic             fault;

  modport master (
    input  start, stage_done, branch_taken, branch_target, halt_req,
    output stage_go, pc_out, busy, halted, instr_count, fault
  );

  modport slave (
    output start, stage_done, branch_taken, branch_target, halt_req,
    input  stage_go, pc_out, busy, halted, instr_count, fault
  );
endinterface

// File: rtl/mips_stage_sequencer.sv
// Multi-cycle controller for the 5-stage MIPS datapath: launches one stage at a time,
// owns the PC and counts retirements. Optional WAIT watchdog enabled by SEQ_WATCHDOG_EN.
module mips_stage_sequencer #(
  parameter int unsigned PC_W        = 4,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned MAX_INSTR   = 0,
  parameter int unsigned WDOG_CYCLES = 64
) (
  input  logic      clk,
  input  logic      rst_n,
  mips_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
`ifdef SEQ_WATCHDOG_EN
    S_FAULT  = 3'd4,
`endif
    S_HALTED = 3'd3
  } state_e;

  localparam logic [PC_W-1:0]  PC_RST    = PC_W'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_INSTR);
  localparam bit               LIMIT_EN  = (MAX_INSTR != 0);
  localparam logic [4:0]       GO_ONE    = 5'b00001;

  state_e           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             pend_br_q, pend_br_d;
  logic [PC_W-1:0]  pend_tgt_q, pend_tgt_d;
  logic             halt_pend_q, halt_pend_d, halt_now;
  logic [4:0]       stage_go_q, stage_go_d;
  logic             busy_q, busy_d;
  logic             halted_q, halted_d;
  logic             done_hit;

`ifdef SEQ_WATCHDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES + 1);
  logic [WDOG_W-1:0] wdog_q, wdog_d, wdog_inc;
  logic              fault_q, fault_d;
`endif

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      idx_q       <= 3'd0;
      pc_q        <= PC_RST;
      cnt_q       <= {CNT_W{1'b0}};
      pend_br_q   <= 1'b0;
      pend_tgt_q  <= {PC_W{1'b0}};
      halt_pend_q <= 1'b0;
      stage_go_q  <= 5'b00000;
      busy_q      <= 1'b0;
      halted_q    <= 1'b0;
`ifdef SEQ_WATCHDOG_EN
      wdog_q      <= {WDOG_W{1'b0}};
      fault_q     <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      pc_q        <= pc_d;
      cnt_q       <= cnt_d;
      pend_br_q   <= pend_br_d;
      pend_tgt_q  <= pend_tgt_d;
      halt_pend_q <= halt_pend_d;
      stage_go_q  <= stage_go_d;
      busy_q      <= busy_d;
      halted_q    <= halted_d;
`ifdef SEQ_WATCHDOG_EN
      wdog_q      <= wdog_d;
      fault_q     <= fault_d;
`endif
    end
  end

  // Next-state, stage index, PC/branch/halt bookkeeping
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    pend_br_d   = pend_br_q;
    pend_tgt_d  = pend_tgt_q;
    halt_pend_d = halt_pend_q;
    done_hit    = bus.stage_done[idx_q];
    cnt_inc     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    halt_now    = halt_pend_q | bus.halt_req;
`ifdef SEQ_WATCHDOG_EN
    wdog_d      = wdog_q;
    wdog_inc    = wdog_q + {{(WDOG_W-1){1'b0}}, 1'b1};
`endif
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (bus.start) begin
          state_d     = S_ISSUE;
          idx_d       = 3'd0;
          pc_d        = PC_RST;
          cnt_d       = {CNT_W{1'b0}};
          pend_br_d   = 1'b0;
          halt_pend_d = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      S_ISSUE: begin
        state_d     = S_WAIT;
        halt_pend_d = halt_now;
`ifdef SEQ_WATCHDOG_EN
        wdog_d      = {WDOG_W{1'b0}};
`endif
      end
      S_WAIT: begin
        halt_pend_d = halt_now;
        if (done_hit && (idx_q == 3'd4)) begin
          // Retire: the halt request seen in this very cycle still counts
          cnt_d     = cnt_inc;
          pc_d      = pend_br_q ? pend_tgt_q : pc_q + {{(PC_W-1){1'b0}}, 1'b1};
          pend_br_d = 1'b0;
          if (halt_now || (LIMIT_EN && (cnt_inc == CNT_LIMIT))) begin
            state_d = S_HALTED;
          end else begin
            state_d = S_ISSUE;
            idx_d   = 3'd0;
          end
        end else if (done_hit) begin
          if (idx_q == 3'd2) begin
            pend_br_d  = bus.branch_taken;
            pend_tgt_d = bus.branch_target;
          end else begin
            pend_br_d  = pend_br_q;
          end
          state_d = S_ISSUE;
          idx_d   = idx_q + 3'd1;
        end else begin
`ifdef SEQ_WATCHDOG_EN
          if (wdog_inc == WDOG_W'(WDOG_CYCLES)) begin
            state_d = S_FAULT;
          end else begin
            wdog_d  = wdog_inc;
          end
`else
          state_d = S_WAIT;
`endif
        end
      end
`ifdef SEQ_WATCHDOG_EN
      S_FAULT: state_d = S_FAULT;
`endif
      default: begin
        state_d = S_IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  // Registered outputs derived from the state being entered
  always_comb begin
    stage_go_d = 5'b00000;
    busy_d     = 1'b0;
    halted_d   = 1'b0;
`ifdef SEQ_WATCHDOG_EN
    fault_d    = 1'b0;
`endif
    case (state_d)
      S_ISSUE: begin
        stage_go_d = GO_ONE << idx_d;
        busy_d     = 1'b1;
      end
      S_WAIT:   busy_d   = 1'b1;
      S_HALTED: halted_d = 1'b1;
`ifdef SEQ_WATCHDOG_EN
      S_FAULT:  fault_d  = 1'b1;
`endif
      S_IDLE:   busy_d   = 1'b0;
      default:  busy_d   = 1'b0;
    endcase
  end

  assign bus.stage_go    = stage_go_q;
  assign bus.pc_out      = pc_q;
  assign bus.busy        = busy_q;
  assign bus.halted      = halted_q;
  assign bus.instr_count = cnt_q;
`ifdef SEQ_WATCHDOG_EN
  assign bus.fault       = fault_q;
`else
  assign bus.fault       = 1'b0;
`endif

endmodule

// File: tb/tb_mips_stage_sequencer.sv
// Randomized scoreboard bench for mips_stage_sequencer: a driver plays the five stages,
// an instruction-level model predicts every launch and halt, a monitor compares them.
module tb_mips_stage_sequencer;
  localparam int unsigned PC_W     = 4;
  localparam int unsigned CNT_W    = 16;
  localparam int unsigned RESET_PC = 15;
  localparam int unsigned WDOG     = 8;

  typedef struct {
    int               kind;   // 0 = stage launch, 1 = entry into HALTED
    int               stage;
    logic [PC_W-1:0]  pc;
    logic [CNT_W-1:0] cnt;
    int               cyc;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  logic halted_prev = 1'b0;
  bit   ok;

  logic [PC_W-1:0]  m_pc;
  logic [PC_W-1:0]  m_tgt;
  logic [CNT_W-1:0] m_cnt;
  bit               m_br;
  bit               m_halt;
  bit               m_halted;

  mips_seq_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

  mips_stage_sequencer #(
    .PC_W(PC_W), .RESET_PC(RESET_PC), .CNT_W(CNT_W), .MAX_INSTR(0), .WDOG_CYCLES(WDOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input int kind, input int stage, input int at);
    exp_t e;
    e.kind = kind; e.stage = stage; e.pc = m_pc; e.cnt = m_cnt; e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every launch pulse and every entry into HALTED must match the next expectation
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.stage_go != 5'b00000) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_go", {27'b0, bus.stage_go}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("go_kind", 32'd0, mon_e.kind);
          chk("stage_go", {27'b0, bus.stage_go}, {27'b0, 5'b00001 << mon_e.stage});
          chk("go_pc_out", {28'b0, bus.pc_out}, {28'b0, mon_e.pc});
          chk("go_instr_count", {16'b0, bus.instr_count}, {16'b0, mon_e.cnt});
          chk("go_cycle", cyc, mon_e.cyc);
          chk("go_busy", {31'b0, bus.busy}, 32'd1);
        end
      end
      if (bus.halted && !halted_prev) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_halt", {31'b0, bus.halted}, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("halt_kind", 32'd1, mon_e.kind);
          chk("halt_pc_out", {28'b0, bus.pc_out}, {28'b0, mon_e.pc});
          chk("halt_instr_count", {16'b0, bus.instr_count}, {16'b0, mon_e.cnt});
          chk("halt_cycle", cyc, mon_e.cyc);
          chk("halt_busy", {31'b0, bus.busy}, 32'd0);
        end
      end
    end
    halted_prev <= bus.halted;
  end

  task automatic check_reset(input string tag);
    chk({tag, "_stage_go"}, {27'b0, bus.stage_go}, 32'd0);
    chk({tag, "_pc_out"}, {28'b0, bus.pc_out}, RESET_PC);
    chk({tag, "_busy"}, {31'b0, bus.busy}, 32'd0);
    chk({tag, "_halted"}, {31'b0, bus.halted}, 32'd0);
    chk({tag, "_instr_count"}, {16'b0, bus.instr_count}, 32'd0);
    chk({tag, "_fault"}, {31'b0, bus.fault}, 32'd0);
  endtask

  task automatic do_start();
    m_pc = RESET_PC[PC_W-1:0]; m_cnt = '0; m_br = 1'b0; m_halt = 1'b0; m_halted = 1'b0;
    bus.start = 1'b1;
    push_exp(0, 0, cyc + 1);
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_go(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      if (bus.stage_go != 5'b00000) seen = 1'b1;
    end
    chk("go_seen", {31'b0, seen}, 32'd1);
  endtask

  // Called at the negedge of stage s's launch cycle; hmode 1/2/3 = halt in ISSUE/first WAIT/done cycle
  task automatic do_stage(input int s, input int dly, input int hmode, input bit br,
                          input logic [PC_W-1:0] tgt);
    logic [4:0] sel;
    int at;
    sel = 5'b00001 << s;
    bus.stage_done = 5'($urandom);
    bus.halt_req   = (hmode == 1);
    @(posedge clk); #1;
    bus.halt_req = (hmode == 2);
    for (int k = 0; k < dly; k++) begin
      bus.stage_done    = 5'($urandom) & ~sel;
      bus.start         = ($urandom_range(0, 3) == 0);
      bus.branch_taken  = 1'($urandom);
      bus.branch_target = 4'($urandom);
      @(posedge clk); #1;
      bus.halt_req = 1'b0;
    end
    bus.start      = 1'b0;
    bus.stage_done = sel | 5'($urandom);
    bus.halt_req   = bus.halt_req | (hmode == 3);
    if (s == 2) begin
      bus.branch_taken = br; bus.branch_target = tgt;
    end else begin
      bus.branch_taken = 1'($urandom); bus.branch_target = 4'($urandom);
    end
    at = cyc + 1;
    @(posedge clk); #1;
    bus.stage_done = 5'b00000;
    bus.halt_req   = 1'b0;
    if (hmode != 0) m_halt = 1'b1;
    if (s == 2) begin
      m_br = br; m_tgt = tgt;
    end
    if (s < 4) begin
      push_exp(0, s + 1, at);
    end else begin
      m_cnt = (m_cnt == {CNT_W{1'b1}}) ? m_cnt : m_cnt + 1'b1;
      m_pc  = m_br ? m_tgt : m_pc + 1'b1;
      m_br  = 1'b0;
      if (m_halt) begin
        m_halted = 1'b1;
        push_exp(1, 0, at);
      end else begin
        push_exp(0, 0, at);
      end
    end
  endtask

  task automatic run_instr(input int dmax, input int hstage, input int hmode, input bit br,
                           input logic [PC_W-1:0] tgt);
    bit seen;
    for (int s = 0; s < 5; s++) begin
      wait_go(seen);
      if (!seen) return;
      do_stage(s, $urandom_range(0, dmax), (s == hstage) ? hmode : 0, br, tgt);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    bus.start = 1'b0; bus.stage_done = 5'b0; bus.branch_taken = 1'b0;
    bus.branch_target = '0; bus.halt_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    bus.halt_req = 1'b1;
    @(posedge clk); #1;
    bus.halt_req = 1'b0;
    check_reset("reset");

    // Back-to-back stages, PC wrap 15->0, branch to 6 then sequential to 7, halt in decode
    do_start();
    run_instr(0, -1, 0, 1'b0, 4'h0);
    run_instr(0, -1, 0, 1'b0, 4'h0);
    run_instr(2, -1, 0, 1'b1, 4'h6);
    run_instr(2, -1, 0, 1'b0, 4'h0);
    run_instr(1, 1, 2, 1'b0, 4'h0);
    repeat (2) @(negedge clk);
    chk("seqA_pc_out", {28'b0, bus.pc_out}, 32'h8);
    chk("seqA_instr_count", {16'b0, bus.instr_count}, 32'd5);

    // Fresh run halted from decode WAIT: exactly one retirement, then HALTED holds
    do_start();
    run_instr(1, 1, 2, 1'b0, 4'h0);
    repeat (4) @(negedge clk);
    chk("halt_halted", {31'b0, bus.halted}, 32'd1);
    chk("halt_stage_go", {27'b0, bus.stage_go}, 32'd0);
    chk("halt_instr_count", {16'b0, bus.instr_count}, 32'd1);
    chk("halt_pc_out", {28'b0, bus.pc_out}, 32'h0);
    bus.halt_req = 1'b1;
    @(negedge clk);
    bus.halt_req = 1'b0;
    do_start();
    run_instr(0, -1, 0, 1'b0, 4'h0);
    run_instr(0, 4, 3, 1'b0, 4'h0);
    @(negedge clk);
    chk("retire_halt_count", {16'b0, bus.instr_count}, 32'd2);

    // Randomized programs, each ending in a halt
    for (int r = 0; r < 4; r++) begin
      do_start();
      for (int i = 0; i < 8 && !m_halted; i++) begin
        if (i == 7 || $urandom_range(0, 7) == 0) begin
          run_instr(3, $urandom_range(0, 4), $urandom_range(1, 3), 1'($urandom), 4'($urandom));
        end else begin
          run_instr(3, -1, 0, 1'($urandom), 4'($urandom));
        end
      end
      repeat (2) @(negedge clk);
      chk("rand_halted", {31'b0, bus.halted}, 32'd1);
    end

    // Foreign done bit ignored while waiting on decode, then reset mid-WAIT
    do_start();
    wait_go(ok);
    do_stage(0, 0, 0, 1'b0, 4'h0);
    wait_go(ok);
    bus.stage_done = 5'b01000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("foreign_done_busy", {31'b0, bus.busy}, 32'd1);
    chk("foreign_done_go", {27'b0, bus.stage_go}, 32'd0);
    bus.stage_done = 5'b00000;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    check_reset("mid_wait_reset");
    repeat (4) @(negedge clk);
    chk("post_reset_busy", {31'b0, bus.busy}, 32'd0);

    // Withheld done: watchdog trip when enabled, otherwise WAIT persists
    do_start();
    wait_go(ok);
`ifdef SEQ_WATCHDOG_EN
    for (int k = 1; k <= WDOG + 1; k++) begin
      @(negedge clk);
      if (k <= WDOG) begin
        chk("wdog_busy", {31'b0, bus.busy}, 32'd1);
        chk("wdog_fault_early", {31'b0, bus.fault}, 32'd0);
      end else begin
        chk("wdog_fault", {31'b0, bus.fault}, 32'd1);
        chk("wdog_busy_off", {31'b0, bus.busy}, 32'd0);
        chk("wdog_stage_go", {27'b0, bus.stage_go}, 32'd0);
      end
    end
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("fault_sticky", {31'b0, bus.fault}, 32'd1);
    chk("fault_start_ignored", {31'b0, bus.busy}, 32'd0);
`else
    repeat (3 * WDOG) @(negedge clk);
    chk("nowdog_busy", {31'b0, bus.busy}, 32'd1);
    chk("nowdog_fault", {31'b0, bus.fault}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_q.delete();
    check_reset("final_reset");

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
